// File: rtl/all_gates.sv
// Registered two-input gate bank (AND/OR/NOT-A/NAND/NOR/XOR/XNOR on y1..y7).
// Define ALLGATE_BIST_EN to compile in the four-pattern built-in self-test.
module all_gates (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
`ifdef ALLGATE_BIST_EN
  input  logic bist_start,
  output logic bist_busy,
  output logic bist_done,
  output logic bist_pass,
`endif
  output logic y1,
  output logic y2,
  output logic y3,
  output logic y4,
  output logic y5,
  output logic y6,
  output logic y7
);

  // Bit 6 is y1, bit 0 is y7.
  function automatic logic [6:0] gates(input logic [1:0] ab);
    logic fa;
    logic fb;
    fa = ab[1];
    fb = ab[0];
    return {fa & fb, fa | fb, ~fa, ~(fa & fb), ~(fa | fb), fa ^ fb, ~(fa ^ fb)};
  endfunction

  logic [1:0] pair_d;
  logic [6:0] y_d;
  logic [6:0] y_q;

`ifdef ALLGATE_BIST_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_t;

  // Independent truth table, so a broken gate core is caught by the self-test.
  function automatic logic [6:0] golden(input logic [1:0] ab);
    logic [6:0] g;
    case (ab)
      2'b00:   g = 7'b0011101;
      2'b01:   g = 7'b0111010;
      2'b10:   g = 7'b0101010;
      default: g = 7'b1100001;
    endcase
    return g;
  endfunction

  bist_state_t state_q;
  logic [1:0]  idx_q;
  logic        fail_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic        mismatch_d;

  assign pair_d     = (state_q == ST_RUN) ? idx_q : {a, b};
  assign mismatch_d = (gates(idx_q) != golden(idx_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bist_start) begin
            state_q <= ST_RUN;
            idx_q   <= 2'd0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          fail_q <= fail_q | mismatch_d;
          idx_q  <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= ~(fail_q | mismatch_d);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bist_busy = busy_q;
  assign bist_done = done_q;
  assign bist_pass = pass_q;
`else
  assign pair_d = {a, b};
`endif

  assign y_d = gates(pair_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= 7'd0;
    end else begin
      y_q <= y_d;
    end
  end

  assign {y1, y2, y3, y4, y5, y6, y7} = y_q;

endmodule

// File: tb/tb_all_gates.sv
// Directed bench for all_gates; BIST steps run only when ALLGATE_BIST_EN is defined.
`timescale 1ns/1ps
module tb_all_gates;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic y1, y2, y3, y4, y5, y6, y7;
  int   errors;
  int   checks;

`ifdef ALLGATE_BIST_EN
  logic bist_start;
  logic bist_busy;
  logic bist_done;
  logic bist_pass;
`endif

  all_gates dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
`ifdef ALLGATE_BIST_EN
    .bist_start(bist_start),
    .bist_busy (bist_busy),
    .bist_done (bist_done),
    .bist_pass (bist_pass),
`endif
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .y5        (y5),
    .y6        (y6),
    .y7        (y7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %-14s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] yv();
    return {y1, y2, y3, y4, y5, y6, y7};
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    a      = 1'b1;
    b      = 1'b1;
`ifdef ALLGATE_BIST_EN
    bist_start = 1'b0;
`endif
    // Reset held across edges with a=b=1.
    tick();
    tick();
    check("reset_y", yv(), 7'b0000000);
`ifdef ALLGATE_BIST_EN
    check("reset_bist", {4'd0, bist_busy, bist_done, bist_pass}, 7'b0000000);
`endif
    #2 rst_n = 1'b1;
    tick();
    check("rel_11", yv(), 7'b1100001);

    // Truth table.
    a = 0; b = 0; tick(); check("tt_00", yv(), 7'b0011101);
    a = 0; b = 1; tick(); check("tt_01", yv(), 7'b0111010);
    a = 1; b = 0; tick(); check("tt_10", yv(), 7'b0101010);
    a = 1; b = 1; tick(); check("tt_11", yv(), 7'b1100001);

    // Latency: mid-cycle change is invisible until the next edge.
    a = 0; b = 0; tick(); check("lat_pre", yv(), 7'b0011101);
    #2 a = 1;
    #1 check("lat_mid", yv(), 7'b0011101);
    tick(); check("lat_post", yv(), 7'b0101010);

    // Asynchronous reset between edges.
    a = 1; b = 1; tick(); check("async_pre", yv(), 7'b1100001);
    #2 rst_n = 1'b0;
    #1 check("async_rst", yv(), 7'b0000000);
    tick(); rst_n = 1'b1;
    a = 0; b = 1; tick(); check("after_async", yv(), 7'b0111010);

`ifdef ALLGATE_BIST_EN
    // Full self-test; ports hold a pattern that differs from the last BIST one.
    a = 1; b = 0;
    bist_start = 1'b1; tick(); bist_start = 1'b0;
    check("bist_e0_busy", {6'd0, bist_busy}, 7'd1);
    tick(); check("bist_e1_y", yv(), 7'b0011101);
    check("bist_e1_busy", {6'd0, bist_busy}, 7'd1);
    bist_start = 1'b1;  // ignored while running
    tick(); check("bist_e2_y", yv(), 7'b0111010);
    bist_start = 1'b0;
    tick(); check("bist_e3_y", yv(), 7'b0101010);
    check("bist_e3_bd", {5'd0, bist_busy, bist_done}, 7'b0000010);
    tick(); check("bist_e4_y", yv(), 7'b1100001);
    check("bist_e4_bdp", {4'd0, bist_busy, bist_done, bist_pass}, 7'b0000011);
    tick(); check("bist_e5_y", yv(), 7'b0101010);
    check("bist_e5_bdp", {4'd0, bist_busy, bist_done, bist_pass}, 7'b0000001);
    tick(); check("bist_e6_bdp", {4'd0, bist_busy, bist_done, bist_pass}, 7'b0000001);

    // Abort during RUN.
    bist_start = 1'b1; tick(); bist_start = 1'b0;
    tick(); tick();
    check("abort_pre", {6'd0, bist_busy}, 7'd1);
    #2 rst_n = 1'b0;
    #1 check("abort_rst", {4'd0, bist_busy, bist_done, bist_pass}, 7'b0000000);
    tick(); rst_n = 1'b1;
    a = 1; b = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_idle", {4'd0, bist_busy, bist_done, bist_pass}, 7'b0000000);
    end
    check("abort_y", yv(), 7'b1100001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/all_gates.md
# all_gates

Registered two-input logic-gate bank: from inputs `a` and `b` it produces the seven basic gate functions on `y1`..`y7`. It is a leaf cell used as a reference/demonstration gate library in the design. Outputs are captured on the clock, so downstream logic always sees glitch-free values. An optional built-in self-test (BIST) sweeps all four input combinations and reports pass/fail.

## Interface
- Parameters: none.
- `clk`  in  1  system clock, rising-edge active.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `a`  in  1  operand A.
- `b`  in  1  operand B.
- `y1`  out  1  registered AND: a & b.
- `y2`  out  1  registered OR: a | b.
- `y3`  out  1  registered NOT A: ~a (`b` is ignored).
- `y4`  out  1  registered NAND: ~(a & b).
- `y5`  out  1  registered NOR: ~(a | b).
- `y6`  out  1  registered XOR: a ^ b.
- `y7`  out  1  registered XNOR: ~(a ^ b).
- BIST ports, present only with `ALLGATE_BIST_EN`:
  - `bist_start`  in  1  start self-test.
  - `bist_busy`  out  1  self-test running.
  - `bist_done`  out  1  one-cycle completion pulse.
  - `bist_pass`  out  1  result of the last self-test.

## Operation
- Gate core is purely combinational: f1..f7 of the operand pair, exactly as listed in Interface.
- Operand pair source:
  - Normally `{a,b}` from the ports.
  - While BIST is in RUN, the internal pattern index `idx[1:0]` drives the core, with a = idx[1] and b = idx[0]. Port inputs are ignored during this time.
- Each rising edge, `y1`..`y7` are loaded with f1..f7 of the selected pair.
- BIST state machine:
  - IDLE:
    - `bist_start`=1 at an edge moves to RUN with idx=0.
    - The internal fail flag clears at the same edge.
  - RUN:
    - Each edge registers f(idx) into `y`.
    - At the same edge, f(idx) is compared against the golden truth table. Any mismatch sets the fail flag.
    - idx increments. When idx=3, the next state is DONE.
  - DONE:
    - `bist_done`=1 for exactly this one cycle.
    - `bist_pass` is loaded with ~fail on entry.
    - Next edge returns to IDLE.
- `bist_busy`=1 exactly while the state is RUN.
- `bist_start` is ignored outside IDLE.
- `bist_pass` holds its value until the next DONE or reset.
- Golden table, in {a,b} order 00/01/10/11, listing y1..y7 per pattern:
  - 00 → 0 0 1 1 1 0 1
  - 01 → 0 1 1 1 0 1 0
  - 10 → 0 1 0 1 0 1 0
  - 11 → 1 1 0 0 0 0 1

## Timing
- Latency: one clock, from input change to output. Inputs are sampled at a rising edge; `y` is valid after that edge.
- Reset, asserted asynchronously:
  - `y1`..`y7`=0 immediately, regardless of inputs.
  - BIST state=IDLE, idx=0, fail=0.
  - `bist_busy`=0, `bist_done`=0, `bist_pass`=0.
- Deassertion takes effect at the first rising edge with `rst_n`=1. That first edge loads the normal gate values.
- BIST sequence:
  - Start sampled at edge E0.
  - Patterns 00, 01, 10, 11 are registered at E1..E4, with `bist_busy` high from E0 to E4.
  - DONE cycle follows E4; IDLE is restored at E5.
  - The first functional output (from ports) is loaded at E5.
- Reset during RUN or DONE aborts the test: IDLE, `bist_pass`=0, no done pulse.
- Inputs changing mid-cycle have no effect until the next edge.

## Configuration
- `ALLGATE_BIST_EN` defined:
  - BIST ports, state machine, pattern counter and checker are compiled in.
- `ALLGATE_BIST_EN` undefined:
  - BIST ports and logic are absent.
  - The core is always driven from `a`/`b`.
  - Otherwise identical behaviour and timing.

## Test plan
- Reset: hold `rst_n`=0 with a=1, b=1 → all y=0; release and clock once → y1..y7 = 1 1 0 0 0 0 1.
- Truth table: apply {a,b}=00, 01, 10, 11, one per clock → y1..y7 = 0011101, 0111010, 0101010, 1100001 one edge after each apply.
- Latency: change a 0→1 at b=0 mid-cycle → y outputs unchanged until the next rising edge, then y6=1, y3=0.
- Async reset mid-operation: assert `rst_n` low between edges with a=1, b=1 → y1..y7 go to 0 without waiting for a clock edge.
- BIST (macro defined): pulse `bist_start` → `bist_busy` high for 4 cycles; y sequence 0011101, 0111010, 0101010, 1100001 regardless of a/b; `bist_done` one cycle; `bist_pass`=1.
- BIST abort: assert `rst_n` low during RUN → `bist_busy`=0, no `bist_done`, `bist_pass`=0; a `bist_start` during RUN without reset is ignored.
